// File: rtl/pipe_perf_monitor_if.sv
// Sideband bus between the CPU probe points and pipe_perf_monitor.
// The master drives pipeline observations and read select; the slave returns counts and status.
interface pipe_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             hd_nostall_i;
  logic             jump_i;
  logic             branch_i;
  logic             eq_i;
  logic [31:0]      pc_i;
  logic             clear_i;
  logic [1:0]       sel_i;
  logic [CNT_W-1:0] data_o;
  logic             running_o;
  logic             done_o;

  modport master (
    output start_i, hd_nostall_i, jump_i, branch_i, eq_i, pc_i, clear_i, sel_i,
    input  data_o, running_o, done_o
  );

  modport slave (
    input  start_i, hd_nostall_i, jump_i, branch_i, eq_i, pc_i, clear_i, sel_i,
    output data_o, running_o, done_o
  );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Saturating cycle/stall/flush counters for the 5-stage pipeline with a self-stopping cycle budget.
// Optional PC snapshot at the stop edge is built only when PERF_PC_SNAPSHOT_EN is defined.
module pipe_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pipe_perf_monitor_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLE_LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] snap_rd;
  logic             stall_ev, flush_ev;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // A bubble caused by a control transfer is a flush, not a load-use stall.
  assign stall_ev = !bus.hd_nostall_i && !bus.jump_i && !bus.branch_i;
  assign flush_ev = bus.jump_i || (bus.branch_i && bus.eq_i);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cyc_d   = cyc_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (bus.clear_i) begin
      state_d = IDLE;
      cyc_d   = '0;
      stall_d = '0;
      flush_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start_i) state_d = RUN;
        RUN: if (bus.start_i) begin
          cyc_d   = sat_inc(cyc_q, 1'b1);
          stall_d = sat_inc(stall_q, stall_ev);
          flush_d = sat_inc(flush_q, flush_ev);
          if ((CYCLE_LIMIT != 0) && (cyc_d == LIMIT)) state_d = DONE;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);

    unique case (bus.sel_i)
      2'd0:    data_d = cyc_q;
      2'd1:    data_d = stall_q;
      2'd2:    data_d = flush_q;
      default: data_d = snap_rd;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst_i) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      data_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      data_q    <= data_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

`ifdef PERF_PC_SNAPSHOT_EN
  logic [CNT_W-1:0] snap_q, snap_d;

  // RUN->DONE only happens through the limit stop, so this marks the stop edge.
  always_comb begin
    snap_d = snap_q;
    if (bus.clear_i)                              snap_d = '0;
    else if ((state_q == RUN) && (state_d == DONE)) snap_d = CNT_W'(bus.pc_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) snap_q <= '0;
    else       snap_q <= snap_d;
  end

  assign snap_rd = snap_q;
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc_i;
  assign snap_rd   = '0;
`endif

  assign bus.data_o    = data_q;
  assign bus.running_o = running_q;
  assign bus.done_o    = done_q;
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: a 32-bit/limit-30 instance and a 4-bit/unlimited instance.
// Expected snapshot read follows PERF_PC_SNAPSHOT_EN.
module tb_pipe_perf_monitor;
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  pipe_perf_monitor_if #(.CNT_W(32)) ifa ();
  pipe_perf_monitor_if #(.CNT_W(4))  ifb ();

  pipe_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(30)) dut_a (.clk_i(clk_i), .rst_i(rst_i), .bus(ifa));
  pipe_perf_monitor #(.CNT_W(4),  .CYCLE_LIMIT(0))  dut_b (.clk_i(clk_i), .rst_i(rst_i), .bus(ifb));

  typedef struct {
    logic        start, hd, jump, branch, eq;
    logic [1:0]  sel;
    logic [31:0] exp_data;
    logic        exp_run, exp_done;
  } vec_t;

  vec_t vt[14];
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef PERF_PC_SNAPSHOT_EN
  localparam logic [31:0] EXP_SNAP = 32'd72;
`else
  localparam logic [31:0] EXP_SNAP = 32'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input logic s, h, j, b, e, input logic [1:0] sel,
                              input logic [31:0] d, input logic r, dn);
    vec_t v;
    v.start = s; v.hd = h; v.jump = j; v.branch = b; v.eq = e;
    v.sel = sel; v.exp_data = d; v.exp_run = r; v.exp_done = dn;
    return v;
  endfunction

  task automatic drive_a(input logic s, h, j, b, e, input logic [1:0] sel);
    ifa.start_i = s; ifa.hd_nostall_i = h; ifa.jump_i = j;
    ifa.branch_i = b; ifa.eq_i = e; ifa.sel_i = sel;
  endtask

  task automatic read_a(input string name, input logic [1:0] sel, input logic [31:0] exp);
    ifa.sel_i = sel;
    step();
    check(name, ifa.data_o, exp);
  endtask

  initial begin
    int n;
    // start, hd_nostall, jump, branch, eq, sel | data_o, running, done (after the edge)
    vt[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0); // entry, not counted
    vt[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0, 1'b1, 1'b0); // stall 1
    vt[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd1, 1'b1, 1'b0); // stall 2
    vt[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'd2, 1'b1, 1'b0); // bubble w/ branch: neither
    vt[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd2, 1'b1, 1'b0); // stall 3
    vt[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'd3, 1'b1, 1'b0); // flush 1 (jump)
    vt[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'd1, 1'b1, 1'b0); // flush 2 (jump)
    vt[7]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 32'd2, 1'b1, 1'b0); // flush 3 (taken branch)
    vt[8]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'd3, 1'b1, 1'b0); // untaken branch
    vt[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd8, 1'b1, 1'b0); // pause 1
    vt[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'd3, 1'b1, 1'b0); // pause 2, events ignored
    vt[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'd3, 1'b1, 1'b0); // pause 3
    vt[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd8, 1'b1, 1'b0); // pause 4
    vt[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd3, 1'b1, 1'b0); // pause 5

    rst_i = 1'b1;
    drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    ifa.clear_i = 1'b0; ifa.pc_i = 32'd0;
    ifb.start_i = 1'b0; ifb.hd_nostall_i = 1'b1; ifb.jump_i = 1'b0; ifb.branch_i = 1'b0;
    ifb.eq_i = 1'b0; ifb.clear_i = 1'b0; ifb.sel_i = 2'd0; ifb.pc_i = 32'd0;

    step();
    check("reset data_o", ifa.data_o, 32'd0);
    check("reset running_o", 32'(ifa.running_o), 32'd0);
    check("reset done_o", 32'(ifa.done_o), 32'd0);
    rst_i = 1'b0;

    // Stall/flush classification and pause, one cycle per row.
    for (int i = 0; i < 14; i++) begin
      drive_a(vt[i].start, vt[i].hd, vt[i].jump, vt[i].branch, vt[i].eq, vt[i].sel);
      step();
      check($sformatf("vec%0d data_o", i), ifa.data_o, vt[i].exp_data);
      check($sformatf("vec%0d running_o", i), 32'(ifa.running_o), 32'(vt[i].exp_run));
      check($sformatf("vec%0d done_o", i), 32'(ifa.done_o), 32'(vt[i].exp_done));
    end

    // 8 counted so far; 22 more reach the limit, 5 cycles later than the unpaused baseline.
    drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 1; i <= 22; i++) begin
      step();
      check($sformatf("paused run done_o @%0d", i), 32'(ifa.done_o), 32'(i == 22));
    end

    // DONE ignores start and events.
    drive_a(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    read_a("done cycles", 2'd0, 32'd30);
    read_a("done stalls", 2'd1, 32'd3);
    read_a("done flushes", 2'd2, 32'd3);
    check("done holds", 32'(ifa.done_o), 32'd1);

    // clear together with start and events wins.
    ifa.clear_i = 1'b1;
    step();
    check("clear running_o", 32'(ifa.running_o), 32'd0);
    check("clear done_o", 32'(ifa.done_o), 32'd0);
    ifa.clear_i = 1'b0;
    drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    read_a("clear cycles", 2'd0, 32'd0);
    read_a("clear stalls", 2'd1, 32'd0);
    read_a("clear flushes", 2'd2, 32'd0);
    read_a("clear snapshot", 2'd3, 32'd0);

    // Unpaused baseline: done on edge 31 counting the entry edge; pc 0x48 on the stop edge.
    drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    n = 0;
    while (!ifa.done_o && n < 100) begin
      ifa.pc_i = (n + 1 == 31) ? 32'h48 : 32'h1000 + 32'(n + 1);
      step();
      n++;
    end
    check("baseline edges to done", 32'(n), 32'd31);
    ifa.pc_i = 32'h2000;
    drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    read_a("baseline cycles", 2'd0, 32'd30);
    read_a("baseline stalls", 2'd1, 32'd0);
    read_a("baseline flushes", 2'd2, 32'd0);
    read_a("baseline snapshot", 2'd3, EXP_SNAP);

    // Reset in mid-RUN drops partial counts.
    ifa.clear_i = 1'b1;
    step();
    ifa.clear_i = 1'b0;
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    for (int i = 0; i < 4; i++) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("midrun reset data_o", ifa.data_o, 32'd0);
    check("midrun reset running_o", 32'(ifa.running_o), 32'd0);
    drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    read_a("midrun reset stalls", 2'd1, 32'd0);
    read_a("midrun reset cycles", 2'd0, 32'd0);

    // 4-bit counters, unlimited: entry + 20 stall cycles saturate at 15.
    ifb.start_i = 1'b1; ifb.hd_nostall_i = 1'b0;
    for (int i = 0; i < 21; i++) step();
    ifb.sel_i = 2'd0;
    step();
    check("sat cycles", 32'(ifb.data_o), 32'd15);
    ifb.sel_i = 2'd1;
    step();
    check("sat stalls", 32'(ifb.data_o), 32'd15);
    ifb.sel_i = 2'd2;
    step();
    check("sat flushes", 32'(ifb.data_o), 32'd0);
    check("sat done_o", 32'(ifb.done_o), 32'd0);
    check("sat running_o", 32'(ifb.running_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
